mmio_bridge: RTL and testbench

// - Parametrised MMIO bridge between the CPU load/store stage and N_SLV peripheral channels (RAM, KBD, SWT, RTC, SEG, LED, serial, ...).
// - Decodes each request by base/mask, forwards it over a valid/ready handshake, and returns one registered response with an error flag.
// - Successor to the fixed combinational decoder: region count and widths are parameters; responses are multi-cycle; unmapped addresses return an error.

---
 rtl/mmio_bridge.sv | 182 ++++++++++++++++++
 tb/tb_mmio_bridge.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// MMIO bridge: base/mask decode of CPU requests onto N_SLV valid/ready slave channels.
// Optional slave timeout: define MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge #(
  parameter int unsigned               ADDR_W   = 32,
  parameter int unsigned               DATA_W   = 64,
  parameter int unsigned               N_SLV    = 4,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0]   SLV_MASK = '0,
  parameter int unsigned               TIMEOUT  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic                      req_wen,
  input  logic [DATA_W-1:0]         req_wdata,
  input  logic [DATA_W/8-1:0]       req_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [N_SLV-1:0]          s_valid,
  input  logic [N_SLV-1:0]          s_ready,
  output logic [ADDR_W-1:0]         s_addr,
  output logic                      s_wen,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic [N_SLV-1:0]          s_rvalid,
  input  logic [N_SLV*DATA_W-1:0]   s_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SEL_W  = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              dec_hit;
  logic [SEL_W-1:0]  dec_sel;
  logic              sel_ready, sel_rvalid;
  logic [DATA_W-1:0] sel_rdata;

  logic              req_ready_d, rsp_valid_d, rsp_err_d, s_wen_d;
  logic [DATA_W-1:0] rsp_rdata_d, s_wdata_d;
  logic [N_SLV-1:0]  s_valid_d;
  logic [ADDR_W-1:0] s_addr_d;
  logic [STRB_W-1:0] s_wstrb_d;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Address decode; the lowest matching channel wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!dec_hit &&
          ((req_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  assign sel_ready  = s_ready[sel_q];
  assign sel_rvalid = s_rvalid[sel_q];
  assign sel_rdata  = s_rdata[sel_q*DATA_W +: DATA_W];

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    s_addr_d    = s_addr;
    s_wen_d     = s_wen;
    s_wdata_d   = s_wdata;
    s_wstrb_d   = s_wstrb;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          s_addr_d  = req_addr;
          s_wen_d   = req_wen;
          s_wdata_d = req_wdata;
          s_wstrb_d = req_wstrb;
          sel_d     = dec_sel;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (dec_hit) begin
            state_d = REQ;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      REQ, WAIT: begin
        if ((state_q == REQ) ? (sel_ready && sel_rvalid) : sel_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = s_wen ? '0 : sel_rdata;
          rsp_err_d   = 1'b0;
        end else if ((state_q == REQ) && sel_ready) begin
          state_d = WAIT;
        end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        // A response arriving in the expiry cycle still wins over the timeout.
        cnt_d = cnt_q + CNT_W'(1);
        if ((state_d != RESP) && (cnt_d == CNT_W'(TIMEOUT))) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
`endif
      end
      default: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
    endcase

    req_ready_d = (state_d == IDLE);
    s_valid_d   = '0;
    if (state_d == REQ) s_valid_d = N_SLV'(1) << sel_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wen     <= 1'b0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      s_valid   <= s_valid_d;
      s_addr    <= s_addr_d;
      s_wen     <= s_wen_d;
      s_wdata   <= s_wdata_d;
      s_wstrb   <= s_wstrb_d;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomized self-checking bench for mmio_bridge against a transaction-level decode/latency model.
`timescale 1ns/1ps
module tb_mmio_bridge;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned N_SLV   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam logic [N_SLV*ADDR_W-1:0] SLV_BASE =
    {32'h8000_1000, 32'hb000_0000, 32'ha000_0000, 32'h8000_0000};
  localparam logic [N_SLV*ADDR_W-1:0] SLV_MASK =
    {32'hffff_f000, 32'hffff_0000, 32'hffff_f000, 32'hf000_0000};

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    req_valid, req_ready, req_wen;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [DATA_W/8-1:0]     req_wstrb;
  logic                    rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0]       rsp_rdata;
  logic [N_SLV-1:0]        s_valid, s_ready, s_rvalid;
  logic [ADDR_W-1:0]       s_addr;
  logic                    s_wen;
  logic [DATA_W-1:0]       s_wdata;
  logic [DATA_W/8-1:0]     s_wstrb;
  logic [N_SLV*DATA_W-1:0] s_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] base_t [4];
  logic [31:0] mask_t [4];

  mmio_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLV(N_SLV),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: first region in table order whose masked address matches.
  function automatic int ref_sel(input logic [31:0] a);
    for (int i = 0; i < 4; i++) if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  // Drive the selected slave as asked; every other channel gets random noise.
  task automatic drive_slaves(input int sel, input bit rdy, input bit rv, input logic [63:0] d);
    for (int i = 0; i < 4; i++) begin
      if (i == sel) begin
        s_ready[i] = rdy;
        s_rvalid[i] = rv;
        s_rdata[i*64 +: 64] = d;
      end else begin
        s_ready[i] = 1'($urandom);
        s_rvalid[i] = 1'($urandom);
        s_rdata[i*64 +: 64] = {$urandom, $urandom};
      end
    end
  endtask

  // One transaction. rdy_dly: extra REQ cycles before s_ready (<0 never);
  // rv_dly: cycles from ready to rvalid (<0 never); rsp_dly: cycles rsp_ready held low.
  task automatic txn(input string tag, input logic [31:0] addr, input bit wen,
                     input logic [63:0] wd, input logic [7:0] ws,
                     input int rdy_dly, input int rv_dly, input int rsp_dly, output int acc);
    int sel, hs_k, rv_k, exp_k, exp_sv, k, first_k, sv_cyc, w;
    bit silent, hand, done, unstable, sv_bad, rr_seen;
    logic [63:0] sdata, exp_rd, rd0;
    logic e0, exp_err;
    logic [N_SLV-1:0] exp_oh;
    sel = ref_sel(addr);
    sdata = {$urandom, $urandom};
    silent = (rdy_dly < 0) || (rv_dly < 0);
    hs_k = (rdy_dly < 0) ? -10 : rdy_dly + 1;
    rv_k = silent ? -10 : hs_k + rv_dly;
    exp_err = (sel < 0) || silent;
    exp_rd = (exp_err || wen) ? 64'h0 : sdata;
    exp_k = (sel < 0) ? 1 : (silent ? int'(TIMEOUT) + 1 : rv_k + 1);
    exp_sv = (sel < 0) ? 0 : ((rdy_dly < 0) ? int'(TIMEOUT) : hs_k);
    exp_oh = '0;
    if (sel >= 0) exp_oh[sel] = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check({tag, "_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_wen = wen; req_wdata = wd; req_wstrb = ws;
    drive_slaves(sel, 1'b0, 1'($urandom), {$urandom, $urandom});
    acc = cyc;
    k = 0; first_k = -1; sv_cyc = 0; rd0 = '0; e0 = 1'b0;
    hand = 0; done = 0; unstable = 0; sv_bad = 0; rr_seen = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      req_valid = 1'b0;
      if (hand) begin
        check({tag, "_post_rv"}, 64'(rsp_valid), 64'd0);
        check({tag, "_post_rr"}, 64'(req_ready), 64'd1);
        check({tag, "_hold_addr"}, 64'(s_addr), 64'(addr));
        rsp_ready = 1'b0;
        done = 1;
      end else begin
        if (k == 1) begin
          check({tag, "_s_addr"}, 64'(s_addr), 64'(addr));
          check({tag, "_s_wen"}, 64'(s_wen), 64'(wen));
          check({tag, "_s_wdata"}, s_wdata, wd);
          check({tag, "_s_wstrb"}, 64'(s_wstrb), 64'(ws));
        end
        if (s_valid != '0) begin
          sv_cyc++;
          if (s_valid != exp_oh) sv_bad = 1;
        end
        if (req_ready) rr_seen = 1;
        if (rsp_valid) begin
          if (first_k < 0) begin
            first_k = k; rd0 = rsp_rdata; e0 = rsp_err;
          end else if (rsp_rdata !== rd0 || rsp_err !== e0) begin
            unstable = 1;
          end
          if (k - first_k >= rsp_dly) begin rsp_ready = 1'b1; hand = 1; end
        end
      end
      drive_slaves(sel, k == hs_k, (k == rv_k) || (first_k >= 0 && 1'($urandom)),
                   (first_k >= 0) ? {$urandom, $urandom} : sdata);
    end
    if (!done) check({tag, "_done"}, 64'd0, 64'd1);
    check({tag, "_lat"}, 64'(first_k), 64'(exp_k));
    check({tag, "_rdata"}, rd0, exp_rd);
    check({tag, "_err"}, 64'(e0), 64'(exp_err));
    check({tag, "_stable"}, 64'(unstable), 64'd0);
    check({tag, "_sv_cycles"}, 64'(sv_cyc), 64'(exp_sv));
    check({tag, "_sv_onehot"}, 64'(sv_bad), 64'd0);
    check({tag, "_rr_low"}, 64'(rr_seen), 64'd0);
  endtask

  initial begin
    int acc0, acc1, r;
    logic [31:0] a;
    base_t = '{32'h8000_0000, 32'ha000_0000, 32'hb000_0000, 32'h8000_1000};
    mask_t = '{32'hf000_0000, 32'hffff_f000, 32'hffff_0000, 32'hffff_f000};
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0; s_ready = '0; s_rvalid = '0; s_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_s_addr", 64'(s_addr), 64'd0);
    check("rst_s_wdata", s_wdata, 64'd0);
    check("rst_s_wstrb", 64'(s_wstrb), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready_after", 64'(req_ready), 64'd1);

    txn("rd_ch1", 32'ha000_0010, 1'b0, 64'h0, 8'hff, 0, 0, 0, acc0);
    txn("wr_ch2", 32'hb000_0100, 1'b1, 64'hdead_beef, 8'h0f, 0, 0, 0, acc0);
    txn("miss", 32'h0000_0004, 1'b0, 64'h0, 8'hff, 0, 0, 0, acc0);
    txn("overlap", 32'h8000_1234, 1'b0, 64'h0, 8'hff, 0, 0, 0, acc0);
    txn("slow", 32'ha000_0200, 1'b0, 64'h0, 8'hff, 2, 4, 4, acc0);
    txn("b2b_a", 32'hb000_0040, 1'b0, 64'h0, 8'hff, 0, 0, 0, acc0);
    txn("b2b_b", 32'hb000_0048, 1'b1, 64'h55, 8'h01, 0, 0, 0, acc1);
    check("b2b_interval", 64'(acc1 - acc0), 64'd3);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    txn("to_req", 32'ha000_0020, 1'b0, 64'h0, 8'hff, -1, 0, 2, acc0);
    txn("to_wait", 32'hb000_0008, 1'b1, 64'h77, 8'h03, 1, -1, 1, acc0);
    txn("after_to", 32'ha000_0028, 1'b0, 64'h0, 8'hff, 0, 1, 0, acc0);
`endif

    // Reset while a request is outstanding; stray slave activity afterwards is ignored.
    req_valid = 1'b1; req_addr = 32'ha000_0040; req_wen = 1'b0; req_wdata = '0; req_wstrb = 8'hff;
    drive_slaves(1, 1'b0, 1'b0, 64'h1);
    @(negedge clk);
    req_valid = 1'b0;
    drive_slaves(1, 1'b0, 1'b0, 64'h1);
    check("mrst_sv_before", 64'(s_valid), 64'h2);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rr_during", 64'(req_ready), 64'd0);
    check("mrst_sv_during", 64'(s_valid), 64'd0);
    check("mrst_addr_during", 64'(s_addr), 64'd0);
    rst = 1'b0;
    drive_slaves(1, 1'b1, 1'b1, 64'h99);
    @(negedge clk);
    check("mrst_rr_after", 64'(req_ready), 64'd1);
    check("mrst_sv_after", 64'(s_valid), 64'd0);
    check("mrst_rspv_after", 64'(rsp_valid), 64'd0);
    drive_slaves(1, 1'b1, 1'b1, 64'h99);
    @(negedge clk);
    check("mrst_rspv_stray", 64'(rsp_valid), 64'd0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      if (r < 4) a = base_t[r] | ($urandom & ~mask_t[r]);
      else a = $urandom;
      txn($sformatf("rnd%0d", n), a, 1'($urandom), {$urandom, $urandom}, 8'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), acc0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
